flex_fifo_log2size: RTL and testbench

Parametrised synchronous FIFO with power-of-2 depth and lap-bit pointer arithmetic, no occupancy counter. Adds a selectable first-word-fall-through (FWFT) read mode, almost-full and almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It is the general-purpose buffer between streaming producers and consumers inside one clock domain.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_ram_1r1w.sv | 36 +++
 rtl/flex_fifo_log2size.sv | 155 +++++++++++++++
 tb/tb_flex_fifo_log2size.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flex_fifo_log2size buffer family.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointers carry one lap bit above the address bits, so occupancy needs the same width.
    function automatic int occ_width(input int size_log2);
        return size_log2 + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_1r1w.sv
// Simple dual-port storage: one write port, one registered read port, array left unreset.
module fifo_ram_1r1w #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Only the output register is reset; it holds its value when no read is issued.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/flex_fifo_log2size.sv
// Power-of-two synchronous FIFO using lap-bit pointers, with optional first-word-fall-through
// output, threshold flags, flush and sticky overflow/underflow flags.
module flex_fifo_log2size
    import fifo_pkg::*;
#(
    parameter int          FIFO_SIZE_LOG2 = 3,
    parameter int          DATA_WIDTH     = 16,
    parameter int          FWFT           = FIFO_MODE_STD,
    parameter int unsigned AFULL_THRESH   = (1 << FIFO_SIZE_LOG2) - 2,
    parameter int unsigned AEMPTY_THRESH  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_ena,
    input  logic                    i_flush,
    input  logic                    i_clr_err,
    input  logic                    i_wr_req,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_rd_req,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_valid,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_ready,
    output logic                    o_afull,
    output logic                    o_aempty,
    output logic [FIFO_SIZE_LOG2:0] o_current_sz,
    output logic                    o_overflow,
    output logic                    o_underflow
);

    localparam int AW      = FIFO_SIZE_LOG2;
    localparam int PW      = occ_width(FIFO_SIZE_LOG2);
    localparam bit IS_FWFT = (FWFT == FIFO_MODE_FWFT);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic [PW-1:0] w_occ;
    logic [PW-1:0] w_rd_ptr_inc;
    logic          w_empty;
    logic          w_full;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_fetch;
    logic [AW-1:0] w_rd_addr;
    logic          w_ovf_set;
    logic          w_unf_set;

    assign w_occ        = r_wr_ptr - r_rd_ptr;
    assign w_rd_ptr_inc = r_rd_ptr + PW'(1);
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // In FWFT the RAM read port doubles as the presentation stage: after a pop it prefetches
    // the word behind the head, but only if that word was already stored before this edge.
    always_comb begin
        w_wr_acc  = i_ena & i_wr_req & ~w_full & ~i_flush;
        w_ovf_set = i_ena & i_wr_req & w_full & ~i_flush;
        w_rd_acc  = 1'b0;
        w_fetch   = 1'b0;
        w_rd_addr = r_rd_ptr[AW-1:0];
        w_unf_set = 1'b0;
        if (IS_FWFT) begin
            w_rd_acc  = i_ena & i_rd_req & r_valid & ~i_flush;
            w_fetch   = i_ena & ~i_flush & (w_rd_acc ? (w_occ > PW'(1)) : (~r_valid & ~w_empty));
            w_rd_addr = w_rd_acc ? w_rd_ptr_inc[AW-1:0] : r_rd_ptr[AW-1:0];
            w_unf_set = i_ena & i_rd_req & ~i_flush & ~r_valid;
        end else begin
            w_rd_acc  = i_ena & i_rd_req & ~w_empty & ~i_flush;
            w_fetch   = w_rd_acc;
            w_unf_set = i_ena & i_rd_req & ~i_flush & w_empty;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_ena) begin
            if (i_flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= w_rd_ptr_inc;
                end
            end
        end
    end

    // Standard mode: one-cycle pulse per read. FWFT: set by a fetch, dropped by a pop without refill.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
        end else if (i_ena) begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (IS_FWFT) begin
                r_valid <= w_fetch | (r_valid & ~w_rd_acc);
            end else begin
                r_valid <= w_rd_acc;
            end
        end
    end

    // A set event in the same cycle as a clear keeps the flag asserted.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_ena) begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (i_clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (i_clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    fifo_ram_1r1w #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (i_data),
        .i_rd_en   (w_fetch),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (o_data)
    );

    assign o_valid      = r_valid;
    assign o_full       = w_full;
    assign o_empty      = w_empty;
    assign o_ready      = ~w_full;
    assign o_afull      = (32'(w_occ) >= AFULL_THRESH);
    assign o_aempty     = (32'(w_occ) <= AEMPTY_THRESH);
    assign o_current_sz = w_occ;
    assign o_overflow   = r_overflow;
    assign o_underflow  = r_underflow;

endmodule

// File: tb/tb_flex_fifo_log2size.sv
// Bench for flex_fifo_log2size: a depth-8 standard FIFO and a depth-4 FWFT FIFO share stimulus
// and are compared against queue-based reference models.
module tb_flex_fifo_log2size;

    logic        clk = 1'b0;
    logic        rstN, ena, flush, clrErr, wrReq, rdReq;
    logic [15:0] din;

    logic [15:0] sData;
    logic        sValid, sFull, sEmpty, sReady, sAfull, sAempty, sOvf, sUnf;
    logic [3:0]  sSz;
    logic [15:0] fData;
    logic        fValid, fFull, fEmpty, fReady, fAfull, fAempty, fOvf, fUnf;
    logic [2:0]  fSz;

    int nChecks = 0;
    int nErrors = 0;

    // Reference state: queues of held words; FWFT words also remember the enabled edge they arrived on.
    logic [15:0] stdQ[$];
    logic [15:0] stdData;
    logic        stdValid, stdOvf, stdUnf;
    logic [15:0] fwQ[$];
    int          fwStamp[$];
    int          fwEdge = 0;
    logic        fwValid, fwOvf, fwUnf;

    flex_fifo_log2size #(.FIFO_SIZE_LOG2(3), .DATA_WIDTH(16), .FWFT(0)) u_std (
        .i_clk(clk), .i_rst_n(rstN), .i_ena(ena), .i_flush(flush), .i_clr_err(clrErr),
        .i_wr_req(wrReq), .i_data(din), .i_rd_req(rdReq), .o_data(sData), .o_valid(sValid),
        .o_full(sFull), .o_empty(sEmpty), .o_ready(sReady), .o_afull(sAfull), .o_aempty(sAempty),
        .o_current_sz(sSz), .o_overflow(sOvf), .o_underflow(sUnf)
    );

    flex_fifo_log2size #(.FIFO_SIZE_LOG2(2), .DATA_WIDTH(16), .FWFT(1)) u_fw (
        .i_clk(clk), .i_rst_n(rstN), .i_ena(ena), .i_flush(flush), .i_clr_err(clrErr),
        .i_wr_req(wrReq), .i_data(din), .i_rd_req(rdReq), .o_data(fData), .o_valid(fValid),
        .o_full(fFull), .o_empty(fEmpty), .o_ready(fReady), .o_afull(fAfull), .o_aempty(fAempty),
        .o_current_sz(fSz), .o_overflow(fOvf), .o_underflow(fUnf)
    );

    always #5 clk = ~clk;

    task automatic setIdle();
        ena = 1'b1; flush = 1'b0; clrErr = 0; wrReq = 0; rdReq = 0; din = '0;
    endtask

    // One clock edge: advance the reference models with the inputs held across it, then settle at negedge.
    task automatic cycle();
        bit sFullM, sEmptyM, sOvSet, sUnSet, fFullM, fOvSet, fUnSet;
        int k;
        @(posedge clk);
        if (!rstN) begin
            stdQ.delete(); stdData = '0; stdValid = 0; stdOvf = 0; stdUnf = 0;
            fwQ.delete(); fwStamp.delete(); fwValid = 0; fwOvf = 0; fwUnf = 0;
        end else if (ena) begin
            sFullM  = (stdQ.size() == 8);
            sEmptyM = (stdQ.size() == 0);
            sOvSet  = wrReq && sFullM && !flush;
            sUnSet  = rdReq && sEmptyM && !flush;
            stdValid = 0;
            if (flush) begin
                stdQ.delete();
            end else begin
                if (rdReq && !sEmptyM) begin stdData = stdQ.pop_front(); stdValid = 1; end
                if (wrReq && !sFullM) stdQ.push_back(din);
            end
            stdOvf = sOvSet ? 1'b1 : (clrErr ? 1'b0 : stdOvf);
            stdUnf = sUnSet ? 1'b1 : (clrErr ? 1'b0 : stdUnf);

            k = fwEdge;
            fFullM = (fwQ.size() == 4);
            fOvSet = wrReq && fFullM && !flush;
            fUnSet = rdReq && !fwValid && !flush;
            if (flush) begin
                fwQ.delete(); fwStamp.delete();
            end else begin
                if (rdReq && fwValid) begin void'(fwQ.pop_front()); void'(fwStamp.pop_front()); end
                if (wrReq && !fFullM) begin fwQ.push_back(din); fwStamp.push_back(k); end
            end
            fwValid = (fwQ.size() > 0) && (fwStamp[0] < k);
            fwOvf = fOvSet ? 1'b1 : (clrErr ? 1'b0 : fwOvf);
            fwUnf = fUnSet ? 1'b1 : (clrErr ? 1'b0 : fwUnf);
            fwEdge = k + 1;
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        setIdle();
        rstN = 1'b0;
        cycle();
        cycle();
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        nChecks++; if (sData !== 16'h0)  begin nErrors++; $display("[TB] FAIL reset_std_data: got %h expected 0000", sData); end
        nChecks++; if (sValid !== 1'b0)  begin nErrors++; $display("[TB] FAIL reset_std_valid: got %b expected 0", sValid); end
        nChecks++; if (sEmpty !== 1'b1)  begin nErrors++; $display("[TB] FAIL reset_std_empty: got %b expected 1", sEmpty); end
        nChecks++; if (sFull !== 1'b0)   begin nErrors++; $display("[TB] FAIL reset_std_full: got %b expected 0", sFull); end
        nChecks++; if (sReady !== 1'b1)  begin nErrors++; $display("[TB] FAIL reset_std_ready: got %b expected 1", sReady); end
        nChecks++; if (sAempty !== 1'b1) begin nErrors++; $display("[TB] FAIL reset_std_aempty: got %b expected 1", sAempty); end
        nChecks++; if (sAfull !== 1'b0)  begin nErrors++; $display("[TB] FAIL reset_std_afull: got %b expected 0", sAfull); end
        nChecks++; if (sSz !== 4'd0)     begin nErrors++; $display("[TB] FAIL reset_std_sz: got %0d expected 0", sSz); end
        nChecks++; if (sOvf !== 1'b0 || sUnf !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_std_err: got %b%b expected 00", sOvf, sUnf); end
        nChecks++; if (fValid !== 1'b0 || fEmpty !== 1'b1 || fSz !== 3'd0) begin nErrors++; $display("[TB] FAIL reset_fw_status: got v%b e%b sz%0d expected v0 e1 sz0", fValid, fEmpty, fSz); end
        nChecks++; if (fData !== 16'h0) begin nErrors++; $display("[TB] FAIL reset_fw_data: got %h expected 0000", fData); end
    endtask

    task automatic test_std_fill_drain();
        logic [15:0] expData;
        doReset();
        for (int i = 0; i < 8; i++) begin
            wrReq = 1; din = 16'h0011 + 16'(i);
            cycle();
            nChecks++; if (sSz !== 4'(i + 1)) begin nErrors++; $display("[TB] FAIL fill_sz[%0d]: got %0d expected %0d", i, sSz, i + 1); end
            nChecks++; if (sAfull !== (i + 1 >= 6)) begin nErrors++; $display("[TB] FAIL fill_afull[%0d]: got %b expected %b", i, sAfull, (i + 1 >= 6)); end
            nChecks++; if (sFull !== (i == 7)) begin nErrors++; $display("[TB] FAIL fill_full[%0d]: got %b expected %b", i, sFull, (i == 7)); end
        end
        din = 16'h0099;
        cycle();
        wrReq = 0;
        nChecks++; if (sOvf !== 1'b1) begin nErrors++; $display("[TB] FAIL fill_overflow: got %b expected 1", sOvf); end
        nChecks++; if (sSz !== 4'd8 || sReady !== 1'b0) begin nErrors++; $display("[TB] FAIL fill_after_ovf: got sz%0d rdy%b expected sz8 rdy0", sSz, sReady); end
        for (int i = 0; i < 8; i++) begin
            rdReq = 1;
            cycle();
            expData = 16'h0011 + 16'(i);
            nChecks++; if (sValid !== 1'b1 || sData !== expData) begin nErrors++; $display("[TB] FAIL drain[%0d]: got v%b %h expected v1 %h", i, sValid, sData, expData); end
        end
        rdReq = 0;
        cycle();
        nChecks++; if (sEmpty !== 1'b1 || sSz !== 4'd0) begin nErrors++; $display("[TB] FAIL drain_empty: got e%b sz%0d expected e1 sz0", sEmpty, sSz); end
        nChecks++; if (sValid !== 1'b0 || sData !== 16'h0018) begin nErrors++; $display("[TB] FAIL drain_hold: got v%b %h expected v0 0018", sValid, sData); end
    endtask

    task automatic test_wrap();
        logic [15:0] w;
        for (int i = 0; i < 20; i++) begin
            w = 16'($urandom);
            wrReq = 1; rdReq = 0; din = w;
            cycle();
            nChecks++; if (sSz !== 4'd1 || sEmpty !== 1'b0 || sFull !== 1'b0) begin nErrors++; $display("[TB] FAIL wrap_wr[%0d]: got sz%0d e%b f%b expected sz1 e0 f0", i, sSz, sEmpty, sFull); end
            wrReq = 0; rdReq = 1;
            cycle();
            nChecks++; if (sValid !== 1'b1 || sData !== w) begin nErrors++; $display("[TB] FAIL wrap_rd[%0d]: got v%b %h expected v1 %h", i, sValid, sData, w); end
            nChecks++; if (sEmpty !== 1'b1 || sSz !== 4'd0) begin nErrors++; $display("[TB] FAIL wrap_empty[%0d]: got e%b sz%0d expected e1 sz0", i, sEmpty, sSz); end
        end
        rdReq = 0;
    endtask

    task automatic test_full_rw();
        logic [15:0] held [8];
        doReset();
        for (int i = 0; i < 8; i++) begin
            held[i] = 16'($urandom); wrReq = 1; din = held[i];
            cycle();
        end
        rdReq = 1; din = 16'hDEAD;
        cycle();
        wrReq = 0;
        nChecks++; if (sValid !== 1'b1 || sData !== held[0]) begin nErrors++; $display("[TB] FAIL fullrw_data: got v%b %h expected v1 %h", sValid, sData, held[0]); end
        nChecks++; if (sOvf !== 1'b1 || sSz !== 4'd7) begin nErrors++; $display("[TB] FAIL fullrw_state: got ovf%b sz%0d expected ovf1 sz7", sOvf, sSz); end
        for (int i = 1; i < 8; i++) begin
            cycle();
            nChecks++; if (sData !== held[i]) begin nErrors++; $display("[TB] FAIL fullrw_drain[%0d]: got %h expected %h", i, sData, held[i]); end
        end
        cycle();
        rdReq = 0;
        nChecks++; if (sUnf !== 1'b1 || sEmpty !== 1'b1) begin nErrors++; $display("[TB] FAIL fullrw_underflow: got unf%b e%b expected unf1 e1", sUnf, sEmpty); end
    endtask

    task automatic test_fwft();
        logic [15:0] expData;
        doReset();
        wrReq = 1; din = 16'h00AB;
        cycle();
        wrReq = 0;
        nChecks++; if (fValid !== 1'b0 || fSz !== 3'd1) begin nErrors++; $display("[TB] FAIL fwft_first_edge: got v%b sz%0d expected v0 sz1", fValid, fSz); end
        cycle();
        nChecks++; if (fValid !== 1'b1 || fData !== 16'h00AB) begin nErrors++; $display("[TB] FAIL fwft_present: got v%b %h expected v1 00ab", fValid, fData); end
        cycle();
        nChecks++; if (fValid !== 1'b1) begin nErrors++; $display("[TB] FAIL fwft_hold: got v%b expected v1", fValid); end
        rdReq = 1;
        cycle();
        nChecks++; if (fValid !== 1'b0 || fEmpty !== 1'b1 || fUnf !== 1'b0) begin nErrors++; $display("[TB] FAIL fwft_pop: got v%b e%b unf%b expected v0 e1 unf0", fValid, fEmpty, fUnf); end
        cycle();
        rdReq = 0;
        nChecks++; if (fUnf !== 1'b1) begin nErrors++; $display("[TB] FAIL fwft_underflow: got %b expected 1", fUnf); end
        clrErr = 1;
        cycle();
        clrErr = 0;
        nChecks++; if (fUnf !== 1'b0) begin nErrors++; $display("[TB] FAIL fwft_clr_err: got %b expected 0", fUnf); end
        for (int i = 0; i < 2; i++) begin
            wrReq = 1; din = 16'h00A0 + 16'(i);
            cycle();
        end
        nChecks++; if (fValid !== 1'b1 || fData !== 16'h00A0) begin nErrors++; $display("[TB] FAIL fwft_prefill: got v%b %h expected v1 00a0", fValid, fData); end
        for (int i = 0; i < 6; i++) begin
            rdReq = 1; din = 16'h00A2 + 16'(i);
            cycle();
            expData = 16'h00A1 + 16'(i);
            nChecks++; if (fValid !== 1'b1 || fData !== expData) begin nErrors++; $display("[TB] FAIL fwft_stream[%0d]: got v%b %h expected v1 %h", i, fValid, fData, expData); end
        end
        setIdle();
    endtask

    task automatic test_flush();
        doReset();
        rdReq = 1;
        cycle();
        rdReq = 0;
        for (int i = 0; i < 5; i++) begin
            wrReq = 1; din = 16'h00B0 + 16'(i);
            cycle();
        end
        wrReq = 0; rdReq = 1;
        cycle();
        flush = 1; wrReq = 1; rdReq = 1; din = 16'h0077;
        cycle();
        setIdle();
        nChecks++; if (sEmpty !== 1'b1 || sSz !== 4'd0 || sValid !== 1'b0) begin nErrors++; $display("[TB] FAIL flush_std_state: got e%b sz%0d v%b expected e1 sz0 v0", sEmpty, sSz, sValid); end
        nChecks++; if (sData !== 16'h00B0) begin nErrors++; $display("[TB] FAIL flush_std_data: got %h expected 00b0", sData); end
        nChecks++; if (sUnf !== 1'b1 || sOvf !== 1'b0) begin nErrors++; $display("[TB] FAIL flush_std_err: got unf%b ovf%b expected unf1 ovf0", sUnf, sOvf); end
        nChecks++; if (fEmpty !== 1'b1 || fValid !== 1'b0 || fOvf !== 1'b1 || fUnf !== 1'b1) begin nErrors++; $display("[TB] FAIL flush_fw_state: got e%b v%b ovf%b unf%b expected e1 v0 ovf1 unf1", fEmpty, fValid, fOvf, fUnf); end
        cycle();
        nChecks++; if (sSz !== 4'd0 || fSz !== 3'd0) begin nErrors++; $display("[TB] FAIL flush_write_dropped: got std%0d fw%0d expected 0 0", sSz, fSz); end
    endtask

    task automatic test_enable();
        doReset();
        for (int i = 0; i < 3; i++) begin
            wrReq = 1; din = 16'h0A01 + 16'(i);
            cycle();
        end
        wrReq = 0; rdReq = 1;
        cycle();
        ena = 0; wrReq = 1; rdReq = 1; flush = 1; clrErr = 1; din = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            cycle();
            nChecks++; if (sSz !== 4'd2 || sValid !== 1'b1 || sData !== 16'h0A01) begin nErrors++; $display("[TB] FAIL ena_std[%0d]: got sz%0d v%b %h expected sz2 v1 0a01", i, sSz, sValid, sData); end
            nChecks++; if (fSz !== 3'd2 || fValid !== 1'b1 || fData !== 16'h0A02) begin nErrors++; $display("[TB] FAIL ena_fw[%0d]: got sz%0d v%b %h expected sz2 v1 0a02", i, fSz, fValid, fData); end
            nChecks++; if (sOvf !== 1'b0 || sUnf !== 1'b0 || fOvf !== 1'b0 || fUnf !== 1'b0) begin nErrors++; $display("[TB] FAIL ena_err[%0d]: got %b%b%b%b expected 0000", i, sOvf, sUnf, fOvf, fUnf); end
        end
        setIdle();
        cycle();
        nChecks++; if (sSz !== 4'd2 || sValid !== 1'b0) begin nErrors++; $display("[TB] FAIL ena_resume: got sz%0d v%b expected sz2 v0", sSz, sValid); end
    endtask

    task automatic test_reset_mid();
        doReset();
        for (int i = 0; i < 6; i++) begin
            wrReq = 1; din = 16'($urandom);
            cycle();
        end
        rdReq = 1; flush = 1; rstN = 0;
        cycle();
        rstN = 1;
        setIdle();
        nChecks++; if (sSz !== 4'd0 || sEmpty !== 1'b1 || sAfull !== 1'b0 || sAempty !== 1'b1) begin nErrors++; $display("[TB] FAIL midreset_std: got sz%0d e%b af%b ae%b expected sz0 e1 af0 ae1", sSz, sEmpty, sAfull, sAempty); end
        nChecks++; if (sData !== 16'h0 || sValid !== 1'b0) begin nErrors++; $display("[TB] FAIL midreset_std_out: got v%b %h expected v0 0000", sValid, sData); end
        nChecks++; if (fOvf !== 1'b0 || fValid !== 1'b0 || fSz !== 3'd0) begin nErrors++; $display("[TB] FAIL midreset_fw: got ovf%b v%b sz%0d expected ovf0 v0 sz0", fOvf, fValid, fSz); end
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 400; c++) begin
            ena    = ($urandom_range(0, 9) != 0);
            wrReq  = ($urandom_range(0, 99) < 55);
            rdReq  = ($urandom_range(0, 99) < 50);
            flush  = ($urandom_range(0, 99) < 3);
            clrErr = ($urandom_range(0, 99) < 5);
            din    = 16'($urandom);
            cycle();
            nChecks++; if (sSz !== 4'(stdQ.size())) begin nErrors++; $display("[TB] FAIL rand_std_sz c%0d: got %0d expected %0d", c, sSz, stdQ.size()); end
            nChecks++; if (sFull !== (stdQ.size() == 8) || sReady !== (stdQ.size() != 8)) begin nErrors++; $display("[TB] FAIL rand_std_full c%0d: got f%b r%b size %0d", c, sFull, sReady, stdQ.size()); end
            nChecks++; if (sEmpty !== (stdQ.size() == 0)) begin nErrors++; $display("[TB] FAIL rand_std_empty c%0d: got %b size %0d", c, sEmpty, stdQ.size()); end
            nChecks++; if (sAfull !== (stdQ.size() >= 6) || sAempty !== (stdQ.size() <= 2)) begin nErrors++; $display("[TB] FAIL rand_std_thresh c%0d: got af%b ae%b size %0d", c, sAfull, sAempty, stdQ.size()); end
            nChecks++; if (sValid !== stdValid || sData !== stdData) begin nErrors++; $display("[TB] FAIL rand_std_out c%0d: got v%b %h expected v%b %h", c, sValid, sData, stdValid, stdData); end
            nChecks++; if (sOvf !== stdOvf || sUnf !== stdUnf) begin nErrors++; $display("[TB] FAIL rand_std_err c%0d: got %b%b expected %b%b", c, sOvf, sUnf, stdOvf, stdUnf); end
            nChecks++; if (fSz !== 3'(fwQ.size()) || fFull !== (fwQ.size() == 4) || fEmpty !== (fwQ.size() == 0)) begin nErrors++; $display("[TB] FAIL rand_fw_size c%0d: got sz%0d f%b e%b expected sz%0d", c, fSz, fFull, fEmpty, fwQ.size()); end
            nChecks++; if (fAfull !== (fwQ.size() >= 2) || fAempty !== (fwQ.size() <= 2)) begin nErrors++; $display("[TB] FAIL rand_fw_thresh c%0d: got af%b ae%b size %0d", c, fAfull, fAempty, fwQ.size()); end
            nChecks++; if (fValid !== fwValid) begin nErrors++; $display("[TB] FAIL rand_fw_valid c%0d: got %b expected %b", c, fValid, fwValid); end
            if (fwValid) begin
                nChecks++; if (fData !== fwQ[0]) begin nErrors++; $display("[TB] FAIL rand_fw_data c%0d: got %h expected %h", c, fData, fwQ[0]); end
            end
            nChecks++; if (fOvf !== fwOvf || fUnf !== fwUnf) begin nErrors++; $display("[TB] FAIL rand_fw_err c%0d: got %b%b expected %b%b", c, fOvf, fUnf, fwOvf, fwUnf); end
        end
        setIdle();
    endtask

    initial begin
        rstN = 1'b0;
        setIdle();
        test_reset();
        test_std_fill_drain();
        test_wrap();
        test_full_rw();
        test_fwft();
        test_flush();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
